serial_fifo_port: RTL

Buffered, parametrised serial port that sits between the processor's serial interface and the external serial device/testbench. Replaces the unbuffered single-byte valid/ready connection with independent TX and RX FIFOs and sticky error flags. Adds an internal loopback mode that routes TX data back into RX for self-test. All transfers use valid/ready handshakes.

---
 rtl/serial_pkg.sv | 8 +
 rtl/sync_fifo.sv | 38 +++
 rtl/serial_fifo_port.sv | 61 ++++++
 3 files changed

// File: rtl/serial_pkg.sv
// serial_pkg: shared defaults and sizing helper for the buffered serial port.
package serial_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO; caller qualifies push/pop against full/empty.
module sync_fifo
  import serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int CW = count_width(DEPTH),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  always_ff @(posedge clock)
    if (push) mem[wp] <= wr_data;
  always_ff @(posedge clock) begin
    if (!reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  assign rd_data = mem[rp];
  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
endmodule

// File: rtl/serial_fifo_port.sv
// serial_fifo_port: TX/RX FIFOs between CPU and line, with loopback and sticky error flags.
module serial_fifo_port
  import serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int CW = count_width(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] cpu_wr_data,
  input  logic             cpu_wr_en,
  output logic             cpu_wr_ready,
  output logic [WIDTH-1:0] cpu_rd_data,
  output logic             cpu_rd_valid,
  input  logic             cpu_rd_en,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic [WIDTH-1:0] rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  input  logic             loopback,
  input  logic             clear_flags,
  output logic [CW-1:0]    tx_count,
  output logic [CW-1:0]    rx_count,
  output logic             tx_overflow,
  output logic             rx_underflow
);
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push, tx_pop, rx_push, rx_pop, xfer;
  logic [WIDTH-1:0] rx_wdata;
  assign xfer         = !tx_empty && !rx_full;
  assign tx_valid     = !tx_empty && !loopback;
  assign rx_ready     = !rx_full && !loopback;
  assign tx_pop       = loopback ? xfer : tx_valid && tx_ready;
  assign rx_push      = loopback ? xfer : rx_valid && rx_ready;
  assign rx_wdata     = loopback ? tx_data : rx_data;
  // A write into a full TX is still taken when the head leaves in the same cycle.
  assign tx_push      = cpu_wr_en && (!tx_full || tx_pop);
  assign rx_pop       = cpu_rd_en && !rx_empty;
  assign cpu_wr_ready = !tx_full;
  assign cpu_rd_valid = !rx_empty;
  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx (
    .clock(clock), .reset(reset), .push(tx_push), .pop(tx_pop), .wr_data(cpu_wr_data),
    .rd_data(tx_data), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );
  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx (
    .clock(clock), .reset(reset), .push(rx_push), .pop(rx_pop), .wr_data(rx_wdata),
    .rd_data(cpu_rd_data), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );
  always_ff @(posedge clock) begin
    if (!reset) begin
      tx_overflow  <= 1'b0;
      rx_underflow <= 1'b0;
    end else begin
      tx_overflow  <= (cpu_wr_en && !tx_push) || (tx_overflow && !clear_flags);
      rx_underflow <= (cpu_rd_en && rx_empty) || (rx_underflow && !clear_flags);
    end
  end
endmodule
